// File: rtl/c16_snd_pkg.sv
// rtl/c16_snd_pkg.sv - shared codes, ctrl bits and FSM states for the c16 sound unit.
// Noise helpers exist only when SND_NOISE_EN is defined.
package c16_snd_pkg;

  localparam logic [1:0] SND_P_PERIOD   = 2'd0;
  localparam logic [1:0] SND_P_VOLUME   = 2'd1;
  localparam logic [1:0] SND_P_DURATION = 2'd2;
  localparam logic [1:0] SND_P_CTRL     = 2'd3;

  localparam int CTRL_EN_BIT = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2,
    ST_HOLD = 2'd3
  } snd_state_e;

`ifdef SND_NOISE_EN
  localparam int          CTRL_NOISE_BIT = 1;
  localparam logic [14:0] LFSR_SEED      = 15'h0001;

  // x^15 + x^14 + 1, shifting toward the msb.
  function automatic logic [14:0] lfsr_next(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction
`endif

endpackage

// File: rtl/c16_snd_voice.sv
// rtl/c16_snd_voice.sv - one tone voice: registers, phase, polarity and its signed contribution.
// LFSR noise mode is built only when SND_NOISE_EN is defined.
module c16_snd_voice
  import c16_snd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [1:0]        w_param,
  input  logic [15:0]       w_val,
  input  logic              step,
  output logic signed [8:0] contrib
);

  logic [15:0] period_q, period_d;
  logic [15:0] phase_q, phase_d;
  logic [15:0] duration_q, duration_d;
  logic [7:0]  volume_q, volume_d;
  logic        en_q, en_d;
  logic        pol_q, pol_d;

  logic        active, wrap, sign, pol_step;
  logic [15:0] phase_inc, phase_step;

`ifdef SND_NOISE_EN
  logic        noise_q, noise_d;
  logic [14:0] lfsr_q, lfsr_d, lfsr_step;
`endif

  always_comb begin
    period_d   = period_q;
    phase_d    = phase_q;
    duration_d = duration_q;
    volume_d   = volume_q;
    en_d       = en_q;
    pol_d      = pol_q;
`ifdef SND_NOISE_EN
    noise_d    = noise_q;
    lfsr_d     = lfsr_q;
    lfsr_step  = lfsr_q;
`endif

    active     = en_q && (period_q != 16'd0);
    phase_inc  = phase_q + 16'd1;
    wrap       = (phase_inc >= period_q);
    phase_step = phase_q;
    pol_step   = pol_q;

    if (active) begin
      phase_step = wrap ? 16'd0 : phase_inc;
      if (wrap) begin
`ifdef SND_NOISE_EN
        if (noise_q) lfsr_step = lfsr_next(lfsr_q);
        else         pol_step  = ~pol_q;
`else
        pol_step = ~pol_q;
`endif
      end
    end

    // The sign reflects this sample's step, so a wrap is heard immediately.
`ifdef SND_NOISE_EN
    sign = noise_q ? lfsr_step[0] : pol_step;
`else
    sign = pol_step;
`endif

    contrib = '0;
    if (active) contrib = sign ? $signed({1'b0, volume_q}) : -$signed({1'b0, volume_q});

    if (step) begin
      phase_d = phase_step;
      pol_d   = pol_step;
`ifdef SND_NOISE_EN
      lfsr_d  = lfsr_step;
`endif
      if (en_q && (duration_q != 16'd0)) begin
        duration_d = duration_q - 16'd1;
        if (duration_q == 16'd1) en_d = 1'b0;
      end
    end

    // A register write overrides whatever the step just computed for that field.
    if (wr_en) begin
      case (w_param)
        SND_P_PERIOD: begin
          period_d = w_val;
          phase_d  = 16'd0;
          pol_d    = 1'b0;
`ifdef SND_NOISE_EN
          lfsr_d   = LFSR_SEED;
`endif
        end
        SND_P_VOLUME:   volume_d   = w_val[7:0];
        SND_P_DURATION: duration_d = w_val;
        SND_P_CTRL: begin
          en_d    = w_val[CTRL_EN_BIT];
`ifdef SND_NOISE_EN
          noise_d = w_val[CTRL_NOISE_BIT];
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q   <= '0;
      phase_q    <= '0;
      duration_q <= '0;
      volume_q   <= '0;
      en_q       <= 1'b0;
      pol_q      <= 1'b0;
`ifdef SND_NOISE_EN
      noise_q    <= 1'b0;
      lfsr_q     <= LFSR_SEED;
`endif
    end else begin
      period_q   <= period_d;
      phase_q    <= phase_d;
      duration_q <= duration_d;
      volume_q   <= volume_d;
      en_q       <= en_d;
      pol_q      <= pol_d;
`ifdef SND_NOISE_EN
      noise_q    <= noise_d;
      lfsr_q     <= lfsr_d;
`endif
    end
  end

endmodule

// File: rtl/c16_snd.sv
// rtl/c16_snd.sv - c16 sound unit: voice bank, sample divider, mixing FSM and codec handshake.
// Optional LFSR noise voices are enabled with SND_NOISE_EN.
module c16_snd
  import c16_snd_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_DIV = 1042,
  parameter int VOL_SHIFT  = 5,
  parameter int OUT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    snd_wen,
  input  logic [1:0]              w_param,
  input  logic [10:0]             w_index,
  input  logic [15:0]             w_val,
  output logic signed [OUT_W-1:0] sample,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overrun
);

  localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W  = 8 + $clog2(NUM_VOICES) + 2;
  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  localparam int WIDE_W = ACC_W + VOL_SHIFT + OUT_W;
  localparam logic signed [WIDE_W-1:0] SAT_MAX = WIDE_W'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [WIDE_W-1:0] SAT_MIN = -SAT_MAX - 1;

  snd_state_e               state_q, state_d;
  logic [VIDX_W-1:0]        v_q, v_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [OUT_W-1:0]  sample_q, sample_d;
  logic                     valid_q, valid_d;
  logic                     overrun_q, overrun_d;
  logic [DIV_W-1:0]         div_q, div_d;

  logic                     tick, idx_ok;
  logic signed [8:0]        contrib [NUM_VOICES];
  logic signed [8:0]        contrib_sel;
  logic signed [WIDE_W-1:0] wide;

  assign idx_ok = (w_index < 11'(NUM_VOICES));

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    c16_snd_voice u_voice (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (snd_wen && idx_ok && (w_index[VIDX_W-1:0] == VIDX_W'(i))),
      .w_param (w_param),
      .w_val   (w_val),
      .step    ((state_q == ST_ACC) && (v_q == VIDX_W'(i))),
      .contrib (contrib[i])
    );
  end

  assign contrib_sel = contrib[v_q];
  assign tick        = (div_q == DIV_W'(SAMPLE_DIV - 1));

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    acc_d     = acc_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    div_d     = tick ? '0 : div_q + DIV_W'(1);
    overrun_d = tick && (state_q != ST_IDLE);
    wide      = WIDE_W'(acc_q) <<< VOL_SHIFT;

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_ACC;
          v_d     = '0;
          acc_d   = '0;
        end
      end
      ST_ACC: begin
        acc_d = acc_q + ACC_W'(contrib_sel);
        if (v_q == VIDX_W'(NUM_VOICES - 1)) state_d = ST_OUT;
        else                                v_d     = v_q + VIDX_W'(1);
      end
      ST_OUT: begin
        if (wide > SAT_MAX)      sample_d = {1'b0, {(OUT_W-1){1'b1}}};
        else if (wide < SAT_MIN) sample_d = {1'b1, {(OUT_W-1){1'b0}}};
        else                     sample_d = wide[OUT_W-1:0];
        valid_d = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (sample_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      v_q       <= '0;
      acc_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      div_q     <= '0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      acc_q     <= acc_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      div_q     <= div_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_c16_snd.sv
// tb/tb_c16_snd.sv - self-checking bench for c16_snd against a per-sample behavioural model.
module tb_c16_snd;

  localparam int NV   = 4;
  localparam int SDIV = 16;
  localparam int VSH  = 7;
  localparam int OW   = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 snd_wen;
  logic [1:0]           w_param;
  logic [10:0]          w_index;
  logic [15:0]          w_val;
  logic signed [OW-1:0] sample;
  logic                 sample_valid;
  logic                 sample_ready;
  logic                 overrun;

  int errors = 0;
  int checks = 0;
  int cyc;
  int last_exp;

  int m_per [NV];
  int m_vol [NV];
  int m_dur [NV];
  int m_phase [NV];
  int m_lfsr [NV];
  bit m_en [NV];
  bit m_pol [NV];
  bit m_noise [NV];

  c16_snd #(
    .NUM_VOICES (NV),
    .SAMPLE_DIV (SDIV),
    .VOL_SHIFT  (VSH),
    .OUT_W      (OW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .snd_wen      (snd_wen),
    .w_param      (w_param),
    .w_index      (w_index),
    .w_val        (w_val),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // Edges since the last reset edge; matches the free-running divider phase.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_per[i] = 0; m_vol[i] = 0; m_dur[i] = 0; m_phase[i] = 0;
      m_lfsr[i] = 1; m_en[i] = 0; m_pol[i] = 0; m_noise[i] = 0;
    end
  endfunction

  function automatic void model_write(input int p, input int idx, input int val);
    if (idx >= NV) return;
    case (p)
      0: begin m_per[idx] = val; m_phase[idx] = 0; m_pol[idx] = 0; m_lfsr[idx] = 1; end
      1: m_vol[idx] = val & 255;
      2: m_dur[idx] = val;
      default: begin m_en[idx] = val[0]; m_noise[idx] = val[1]; end
    endcase
  endfunction

  function automatic int model_sample();
    int sum;
    int s;
    bit active;
    bit sgn;
    sum = 0;
    for (int i = 0; i < NV; i++) begin
      active = m_en[i] && (m_per[i] != 0);
      if (active) begin
        m_phase[i] = m_phase[i] + 1;
        if (m_phase[i] >= m_per[i]) begin
          m_phase[i] = 0;
`ifdef SND_NOISE_EN
          if (m_noise[i])
            m_lfsr[i] = ((m_lfsr[i] << 1) | (((m_lfsr[i] >> 14) ^ (m_lfsr[i] >> 13)) & 1)) & 32'h7fff;
          else
            m_pol[i] = !m_pol[i];
`else
          m_pol[i] = !m_pol[i];
`endif
        end
      end
      sgn = m_pol[i];
`ifdef SND_NOISE_EN
      if (m_noise[i]) sgn = m_lfsr[i][0];
`endif
      if (active) sum += sgn ? m_vol[i] : -m_vol[i];
      if (m_en[i] && m_dur[i] != 0) begin
        m_dur[i] = m_dur[i] - 1;
        if (m_dur[i] == 0) m_en[i] = 0;
      end
    end
    s = sum * (1 << VSH);
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_write(input int p, input int idx, input int val);
    w_param = p[1:0];
    w_index = idx[10:0];
    w_val   = val[15:0];
    snd_wen = 1'b1;
    @(negedge clk);
    snd_wen = 1'b0;
    model_write(p, idx, val);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!sample_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!sample_valid) begin
      checks++;
      errors++;
      $error("FAIL wait_valid timeout observed=0 expected=1");
    end
  endtask

  task automatic next_sample(input string tag);
    last_exp = model_sample();
    wait_valid();
    chk(tag, sample, last_exp);
  endtask

  task automatic accept();
    int n;
    sample_ready = 1'b1;
    @(negedge clk);
    n = 1;
    while (sample_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    sample_ready = 1'b0;
    if (sample_valid) begin
      checks++;
      errors++;
      $error("FAIL accept timeout observed=1 expected=0");
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      accept();
      next_sample(tag);
    end
  endtask

  task automatic wait_cyc_mod(input int m);
    int n;
    n = 0;
    while ((cyc % SDIV) != m && n < 4 * SDIV) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int cnt;
    int dur_exp [5];
    int nw, p, idx, val;

    reset = 1'b1; snd_wen = 1'b0; sample_ready = 1'b0;
    w_param = '0; w_index = '0; w_val = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_sample", sample, 0);
    chk("reset_valid", sample_valid, 0);
    chk("reset_overrun", overrun, 0);
    reset = 1'b0;

    // Idle voices produce silence; first sample appears NUM_VOICES+1 cycles after the tick.
    next_sample("zero");
    chk("latency", cyc % SDIV, NV + 1);
    run(2, "zero");

    do_write(0, 0, 4);
    do_write(1, 0, 100);
    do_write(3, 0, 1);
    accept();
    next_sample("tone");
    chk("tone_first", sample, -(100 * (1 << VSH)));
    run(9, "tone");

    for (int i = 0; i < NV; i++) begin
      do_write(0, i, 1);
      do_write(1, i, 255);
      do_write(3, i, 1);
    end
    accept();
    next_sample("sat_hi");
    chk("sat_hi_const", sample, 32767);
    accept();
    next_sample("sat_lo");
    chk("sat_lo_const", sample, -32768);

    do_write(3, 0, 0);
    do_write(3, 2, 0);
    do_write(3, 3, 0);
    do_write(2, 1, 3);
    dur_exp = '{32640, -32640, 32640, 0, 0};
    for (int i = 0; i < 5; i++) begin
      accept();
      next_sample("dur");
      chk("dur_const", sample, dur_exp[i]);
    end

    for (int r = 0; r < 6; r++) begin
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) begin
        p   = $urandom_range(0, 3);
        idx = $urandom_range(0, 5);
        case (p)
          0: val = $urandom_range(0, 6);
          1: val = $urandom_range(0, 255);
          2: val = $urandom_range(0, 5);
          default: val = $urandom_range(0, 3);
        endcase
        do_write(p, idx, val);
      end
      run(4, "rand");
    end

    for (int k = 0; k < 4; k++) do_write(k, 9, $urandom_range(0, 65535));
    run(4, "idx9");

    // Hold the sample for 32 cycles: exactly two ticks are dropped.
    cnt = 0;
    for (int j = 0; j < 32; j++) begin
      chk("ovr_cycle", overrun, ((cyc % SDIV) == 0) ? 1 : 0);
      if (overrun) cnt++;
      @(negedge clk);
    end
    chk("ovr_count", cnt, 2);
    chk("hold_sample", sample, last_exp);
    chk("hold_valid", sample_valid, 1);
    run(3, "after_bp");

    do_write(3, 0, 0);
    do_write(3, 1, 0);
    do_write(3, 3, 0);
    do_write(0, 2, 1);
    do_write(1, 2, 50);
    do_write(2, 2, 0);
    do_write(3, 2, 1);
    accept();
    wait_cyc_mod(2);
    w_param = 2'd0; w_index = 11'd2; w_val = 16'd5; snd_wen = 1'b1;
    @(negedge clk);
    snd_wen = 1'b0;
    last_exp = model_sample();
    model_write(0, 2, 5);
    wait_valid();
    chk("collide", sample, last_exp);
    accept();
    next_sample("post_collide");
    chk("post_collide_const", sample, -50 * (1 << VSH));

    accept();
    wait_cyc_mod(2);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_acc_valid", sample_valid, 0);
    chk("rst_acc_sample", sample, 0);
    chk("rst_acc_overrun", overrun, 0);
    reset = 1'b0;
    model_reset();
    next_sample("post_rst");
    reset = 1'b1;
    @(negedge clk);
    chk("rst_hold_valid", sample_valid, 0);
    chk("rst_hold_sample", sample, 0);
    reset = 1'b0;
    model_reset();
    next_sample("post_rst2");
    accept();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
